imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage of the RISC-V core. It decodes I, S, B, U and J immediates plus OP-IMM shift amounts and sign-extends them to XLEN. Results are delivered through a valid/ready pipeline stage with a 2-entry skid buffer, so back-pressure from execute never drops an instruction. A side-band tag (PC, rd, etc.) travels with each instruction, and a flush input squashes everything in flight.

---
 rtl/imm_gen_pipe.sv | 155 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator for decode: combinational I/S/B/U/J/shamt decode
// feeding a registered valid/ready stage with a 2-entry skid buffer and flush.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // State encoding doubles as the {skid, main} valid bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t             state;
    entry_t             main_q;
    entry_t             skid_q;
    entry_t             dec;
    logic signed [31:0] imm32;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Decode to a sign-carrying 32-bit value, then widen to XLEN by sign extension.
    always_comb begin
        imm32   = '0;
        dec.fmt = FMT_NONE;
        dec.tag = in_tag;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec.fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.fmt = FMT_SHAMT;
                    imm32   = 32'(in_instr[SHAMT_W+19:20]);
                end else begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                dec.fmt = FMT_NONE;
                imm32   = '0;
            end
        endcase
        dec.imm = XLEN'(imm32);
    end

    assign in_ready  = rst_n & ~state[1];
    assign out_valid = state[0];
    assign accept    = in_valid & in_ready;

    // Skid FSM: flush outranks accept/deliver; data registers hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= dec;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        main_q <= dec;
                    end else if (accept) begin
                        skid_q <= dec;
                        state  <= FULL;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_imm = main_q.imm;
    assign out_fmt = main_q.fmt;
    assign out_tag = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, table-driven
// decode streams plus back-pressure, flush and reset-while-full sequences.
module tb_imm_gen_pipe;

    localparam int unsigned TAG_W = 8;

    typedef struct {
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
        logic [63:0]      imm;
        logic [2:0]       fmt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             flush;

    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0]      a_in_instr;
    logic [TAG_W-1:0] a_in_tag, a_out_tag;
    logic [31:0]      a_out_imm;
    logic [2:0]       a_out_fmt;

    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0]      b_in_instr;
    logic [TAG_W-1:0] b_in_tag, b_out_tag;
    logic [63:0]      b_out_imm;
    logic [2:0]       b_out_fmt;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_tag(a_out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_tag(b_out_tag)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input logic v, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic [TAG_W-1:0] tag);
        chk({name, ".valid"}, 64'(a_out_valid), 64'(v));
        chk({name, ".imm"},   64'(a_out_imm),   64'(imm));
        chk({name, ".fmt"},   64'(a_out_fmt),   64'(fmt));
        chk({name, ".tag"},   64'(a_out_tag),   64'(tag));
    endtask

    vec_t v32 [12];
    vec_t v64 [3];

    initial begin
        v32[0]  = '{32'hFFF00093, 8'h01, 64'hFFFFFFFF, 3'd1};
        v32[1]  = '{32'h0020A423, 8'h02, 64'h00000008, 3'd2};
        v32[2]  = '{32'hFE000EE3, 8'h03, 64'hFFFFFFFC, 3'd3};
        v32[3]  = '{32'h123450B7, 8'h04, 64'h12345000, 3'd4};
        v32[4]  = '{32'h001000EF, 8'h05, 64'h00000800, 3'd5};
        v32[5]  = '{32'h4030D093, 8'h06, 64'h00000003, 3'd6};
        v32[6]  = '{32'h0000007F, 8'h07, 64'h00000000, 3'd0};
        v32[7]  = '{32'h000080E7, 8'h08, 64'h00000000, 3'd1};
        v32[8]  = '{32'h00109093, 8'h09, 64'h00000001, 3'd6};
        v32[9]  = '{32'hFFFFF017, 8'h0A, 64'hFFFFF000, 3'd4};
        v32[10] = '{32'hFE20AFA3, 8'h0B, 64'hFFFFFFFF, 3'd2};
        v32[11] = '{32'hFFDFF06F, 8'h0C, 64'hFFFFFFFC, 3'd5};

        v64[0]  = '{32'hFFF00093, 8'h41, 64'hFFFFFFFFFFFFFFFF, 3'd1};
        v64[1]  = '{32'h800000B7, 8'h42, 64'hFFFFFFFF80000000, 3'd4};
        v64[2]  = '{32'h03F0D093, 8'h43, 64'h000000000000003F, 3'd6};

        rst_n = 1'b0; flush = 1'b0;
        a_in_valid = 1'b0; a_in_instr = '0; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_instr = '0; b_in_tag = '0; b_out_ready = 1'b1;

        // Reset state
        step(); step();
        chk_a("rst32", 1'b0, 32'h0, 3'd0, 8'h0);
        chk("rst32.in_ready", 64'(a_in_ready), 64'd0);
        chk("rst64.valid", 64'(b_out_valid), 64'd0);
        chk("rst64.imm", b_out_imm, 64'd0);
        chk("rst64.in_ready", 64'(b_in_ready), 64'd0);
        rst_n = 1'b1;
        step();

        // XLEN=32 full-rate stream, latency 1
        a_in_valid = 1'b1; a_in_instr = v32[0].instr; a_in_tag = v32[0].tag;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk_a($sformatf("s32[%0d]", i - 1), 1'b1, v32[i-1].imm[31:0], v32[i-1].fmt, v32[i-1].tag);
            chk($sformatf("s32[%0d].in_ready", i - 1), 64'(a_in_ready), 64'd1);
            if (i < 12) begin
                a_in_instr = v32[i].instr; a_in_tag = v32[i].tag;
            end else begin
                a_in_valid = 1'b0;
            end
        end
        step();
        chk("s32.drain.valid", 64'(a_out_valid), 64'd0);
        chk("s32.hold.tag", 64'(a_out_tag), 64'(v32[11].tag));

        // XLEN=64 vectors
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1; b_in_instr = v64[i].instr; b_in_tag = v64[i].tag;
            step();
            b_in_valid = 1'b0;
            chk($sformatf("s64[%0d].valid", i), 64'(b_out_valid), 64'd1);
            chk($sformatf("s64[%0d].imm", i), b_out_imm, v64[i].imm);
            chk($sformatf("s64[%0d].fmt", i), 64'(b_out_fmt), 64'(v64[i].fmt));
            chk($sformatf("s64[%0d].tag", i), 64'(b_out_tag), 64'(v64[i].tag));
        end

        // Back-pressure: tags 1,2,3 with out_ready low for 4 cycles
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_instr = 32'hFFF00093; a_in_tag = 8'd1;
        chk("bp.c0.in_ready", 64'(a_in_ready), 64'd1);
        step();
        chk_a("bp.c1", 1'b1, 32'hFFFFFFFF, 3'd1, 8'd1);
        chk("bp.c1.in_ready", 64'(a_in_ready), 64'd1);
        a_in_instr = 32'h0020A423; a_in_tag = 8'd2;
        step();
        chk("bp.c2.in_ready", 64'(a_in_ready), 64'd0);
        a_in_instr = 32'h123450B7; a_in_tag = 8'd3;
        step();
        chk("bp.c3.in_ready", 64'(a_in_ready), 64'd0);
        chk("bp.c3.tag", 64'(a_out_tag), 64'd1);
        step();
        chk_a("bp.c4", 1'b1, 32'hFFFFFFFF, 3'd1, 8'd1);
        a_out_ready = 1'b1;
        step();
        chk_a("bp.rel1", 1'b1, 32'h00000008, 3'd2, 8'd2);
        chk("bp.rel1.in_ready", 64'(a_in_ready), 64'd1);
        step();
        chk_a("bp.rel2", 1'b1, 32'h12345000, 3'd4, 8'd3);
        a_in_valid = 1'b0;
        step();
        chk("bp.drain.valid", 64'(a_out_valid), 64'd0);

        // Flush in FULL with an input presented
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_instr = 32'h001000EF; a_in_tag = 8'd10;
        step();
        a_in_instr = 32'h0020A423; a_in_tag = 8'd11;
        step();
        chk("fl.full.in_ready", 64'(a_in_ready), 64'd0);
        flush = 1'b1; a_in_instr = 32'h123450B7; a_in_tag = 8'd12;
        step();
        flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("fl.valid", 64'(a_out_valid), 64'd0);
        chk("fl.in_ready", 64'(a_in_ready), 64'd1);
        chk("fl.hold.tag", 64'(a_out_tag), 64'd10);
        step();
        chk("fl.after.valid", 64'(a_out_valid), 64'd0);

        // Flush in ONE while an accept is possible: the input is discarded
        a_in_valid = 1'b1; a_in_instr = 32'hFFF00093; a_in_tag = 8'd13;
        step();
        chk("fl1.pre.tag", 64'(a_out_tag), 64'd13);
        flush = 1'b1; a_out_ready = 1'b0; a_in_tag = 8'd14;
        step();
        flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("fl1.valid", 64'(a_out_valid), 64'd0);
        step();
        chk("fl1.after.valid", 64'(a_out_valid), 64'd0);

        // Reset while FULL
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_instr = 32'hFE000EE3; a_in_tag = 8'd20;
        step();
        a_in_tag = 8'd21;
        step();
        chk("rf.full.in_ready", 64'(a_in_ready), 64'd0);
        rst_n = 1'b0; a_in_valid = 1'b0;
        step();
        chk_a("rf.rst", 1'b0, 32'h0, 3'd0, 8'd0);
        chk("rf.rst.in_ready", 64'(a_in_ready), 64'd0);
        rst_n = 1'b1; a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_instr = 32'h001000EF; a_in_tag = 8'd22;
        step();
        a_in_valid = 1'b0;
        chk_a("rf.first", 1'b1, 32'h00000800, 3'd5, 8'd22);
        step();
        chk("rf.drain.valid", 64'(a_out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
